// File: rtl/vxe_fifo_lvl.sv
// vxe_fifo_lvl: single-clock first-word-fall-through FIFO with an occupancy
// level, almost-full/almost-empty decodes and sticky overflow/underflow flags.
//
// Ports:
//   clk       rising-edge clock
//   nrst      synchronous active-low reset (highest priority)
//   clr       synchronous flush, priority over wr/rd
//   data_in   write data
//   wr        write request, accepted when in_rdy
//   in_rdy    not full
//   data_out  head-of-queue data (valid when out_vld)
//   rd        read request (pop), accepted when out_vld
//   out_vld   not empty
//   level     occupancy 0..DEPTH
//   afull     level >= AFULL_THR
//   aempty    level <= AEMPTY_THR
//   ovf       sticky: wr seen while full
//   udf       sticky: rd seen while empty
module vxe_fifo_lvl #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH_POW2 = 3,
    parameter int unsigned AFULL_THR  = (1 << DEPTH_POW2) - 1,
    parameter int unsigned AEMPTY_THR = 1
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  clr,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  wr,
    output logic                  in_rdy,
    output logic [DATA_WIDTH-1:0] data_out,
    input  logic                  rd,
    output logic                  out_vld,
    output logic [DEPTH_POW2:0]   level,
    output logic                  afull,
    output logic                  aempty,
    output logic                  ovf,
    output logic                  udf
);

    localparam int unsigned DEPTH = 1 << DEPTH_POW2;

    localparam logic [DEPTH_POW2:0] DEPTH_L = DEPTH[DEPTH_POW2:0];
    localparam logic [DEPTH_POW2:0] AF_L    = AFULL_THR[DEPTH_POW2:0];
    localparam logic [DEPTH_POW2:0] AE_L    = AEMPTY_THR[DEPTH_POW2:0];
    localparam logic [DEPTH_POW2:0] ONE_L   = {{DEPTH_POW2{1'b0}}, 1'b1};

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Pointers are exactly DEPTH_POW2 bits, so they wrap at DEPTH by
    // plain binary overflow.
    logic [DEPTH_POW2-1:0] wptr;
    logic [DEPTH_POW2-1:0] rptr;

    logic wr_ok;
    logic rd_ok;

    assign in_rdy   = (level != DEPTH_L);
    assign out_vld  = (level != '0);
    assign afull    = (level >= AF_L);
    assign aempty   = (level <= AE_L);
    assign data_out = mem[rptr];

    // Acceptance is judged on the current level only, so a full FIFO
    // never takes a write in the same cycle it pops, and an empty FIFO
    // never bypasses a write straight to a same-cycle read.
    assign wr_ok = wr && in_rdy && !clr;
    assign rd_ok = rd && out_vld && !clr;

    always_ff @(posedge clk) begin
        if (!nrst) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
            ovf   <= 1'b0;
            udf   <= 1'b0;
        end else if (clr) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
            ovf   <= 1'b0;
            udf   <= 1'b0;
        end else begin
            if (wr_ok) begin
                wptr <= wptr + 1'b1;
            end
            if (rd_ok) begin
                rptr <= rptr + 1'b1;
            end
            unique case ({wr_ok, rd_ok})
                2'b10:   level <= level + ONE_L;
                2'b01:   level <= level - ONE_L;
                default: level <= level;
            endcase
            if (wr && !in_rdy) begin
                ovf <= 1'b1;
            end
            if (rd && !out_vld) begin
                udf <= 1'b1;
            end
        end
    end

    // Storage carries no reset; contents are meaningless while empty.
    // wr_ok already excludes clr, and nrst gates the write explicitly.
    always_ff @(posedge clk) begin
        if (nrst && wr_ok) begin
            mem[wptr] <= data_in;
        end
    end

endmodule

// File: doc/vxe_fifo_lvl.md
VXE_FIFO_LVL -- requirements
Module: vxe_fifo_lvl

Interface
REQ-001 Parameter DATA_WIDTH, default 32, data word width in bits.
REQ-002 Parameter DEPTH_POW2, default 3, depth = 2^DEPTH_POW2 entries; legal range 1..6.
REQ-003 Parameter AFULL_THR, default 2^DEPTH_POW2-1, almost-full threshold; legal range 1..DEPTH.
REQ-004 Parameter AEMPTY_THR, default 1, almost-empty threshold; legal range 0..DEPTH-1.
REQ-005 clk  input  1  single clock; all logic on rising edge.
REQ-006 nrst  input  1  reset, synchronous, active-low.
REQ-007 clr  input  1  synchronous flush, active-high.
REQ-008 data_in  input  DATA_WIDTH  write data.
REQ-009 wr  input  1  write request.
REQ-010 in_rdy  output  1  FIFO can accept a write (not full).
REQ-011 data_out  output  DATA_WIDTH  head-of-queue data.
REQ-012 rd  input  1  read request (pop).
REQ-013 out_vld  output  1  data_out holds valid data (not empty).
REQ-014 level  output  DEPTH_POW2+1  current occupancy, 0..DEPTH.
REQ-015 afull  output  1  level >= AFULL_THR.
REQ-016 aempty  output  1  level <= AEMPTY_THR.
REQ-017 ovf  output  1  sticky overflow: wr asserted while full.
REQ-018 udf  output  1  sticky underflow: rd asserted while empty.

Function
REQ-019 Write accepted when wr && in_rdy && !clr: data_in stored at write pointer, write pointer increments modulo DEPTH.
REQ-020 Read accepted when rd && out_vld && !clr: read pointer increments modulo DEPTH.
REQ-021 data_out driven combinationally from storage at read pointer (first-word fall-through); first written word visible the cycle after its write.
REQ-022 level +1 on accepted write only, -1 on accepted read only, unchanged when both or neither accepted.
REQ-023 in_rdy = (level != DEPTH); out_vld = (level != 0); both decoded from level, no separate last-operation flag.
REQ-024 Full with wr and rd same cycle: read accepted, write rejected, ovf set, level becomes DEPTH-1.
REQ-025 Empty with wr and rd same cycle: write accepted, read rejected (no bypass), udf set, level becomes 1.
REQ-026 afull, aempty combinational decodes of level.
REQ-027 ovf/udf remain set until clr or reset; rejected operations never modify storage or pointers.
REQ-028 clr has priority over rd and wr: pointers and level to 0, ovf/udf to 0, same-cycle write discarded.
REQ-029 Pointers wrap naturally at DEPTH; level width DEPTH_POW2+1 so DEPTH is representable without aliasing.

Reset
REQ-030 While nrst low at a rising clk edge: pointers 0, level 0, ovf 0, udf 0; hence in_rdy 1, out_vld 0, afull 0 (AFULL_THR>=1), aempty 1.
REQ-031 Reset mid-operation discards all contents; storage array not reset, data_out undefined while out_vld 0.
REQ-032 nrst has priority over clr, wr and rd.

Structure
REQ-033 Single self-contained module; no shared package, all constants derived locally from parameters.
REQ-034 No sub-module; storage is a flop array indexed by pointers, kept small (DEPTH <= 64).

Verification (DATA_WIDTH=8, DEPTH_POW2=2, AFULL_THR=3, AEMPTY_THR=1)
REQ-035 Reset, then 4 writes 0x11..0x44 -> level 1,2,3,4; afull at level 3; in_rdy 0 at 4; reads return 0x11,0x22,0x33,0x44 in order, out_vld 0 after last.
REQ-036 Full, wr=1 rd=1 data 0x55 -> 0x11 popped, 0x55 dropped, level 3, ovf 1, in_rdy 1.
REQ-037 Empty, wr=1 rd=1 data 0x66 -> level 1, udf 1, data_out 0x66 next cycle.
REQ-038 Level 2, continuous wr+rd for 10 cycles with incrementing data -> level stays 2, output order preserved across pointer wrap.
REQ-039 Level 3 with ovf set, clr=1 with wr=1 -> next cycle level 0, ovf 0, out_vld 0, aempty 1; write dropped.
REQ-040 Level 3, nrst low one cycle with wr=1 rd=1 -> level 0, flags 0, in_rdy 1, out_vld 0.
